// File: rtl/eci_mob_lo_sched.sv
// eci_mob_lo_sched: credit-aware round-robin scheduler feeding the ECI MOB low-bandwidth stream.
// Define ECI_MOB_LO_SCHED_PRIO0_EN to give requester 0 strict priority over the round-robin.

module eci_mob_lo_pool #(
  parameter int CNT_W       = 5,
  parameter int CREDIT_INIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic link_up,
  input  logic grant,
  input  logic ret,
  output logic nz,
  output logic ovf
);
  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] INIT = CNT_W'(CREDIT_INIT);

  logic [CNT_W-1:0] cnt;

  assign nz  = |cnt;
  // A return that coincides with a grant nets to zero and cannot overflow.
  assign ovf = link_up && ret && !grant && (cnt == MAX);

  always_ff @(posedge clk or posedge reset)
    if (reset)                              cnt <= INIT;
    else if (!link_up)                      cnt <= INIT;
    else if (grant && !ret)                 cnt <= cnt - 1'b1;
    else if (ret && !grant && cnt != MAX)   cnt <= cnt + 1'b1;
endmodule

module eci_mob_lo_sched #(
  parameter int NUM_REQ     = 8,
  parameter int CREDIT_INIT = 8,
  parameter int CNT_W       = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0][63:0] req_data,
  input  logic [NUM_REQ-1:0][3:0]  req_vc_no,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [63:0]              mob_lo_data,
  output logic [3:0]               mob_lo_vc_no,
  output logic                     mob_lo_valid,
  input  logic                     mob_lo_ready,
  input  logic [12:0]              mob_credit_return,
  input  logic                     link_up,
  output logic [NUM_REQ-1:0]       credits_avail,
  output logic                     err_credit_ovf
);
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef ECI_MOB_LO_SCHED_PRIO0_EN
  localparam logic [RR_W-1:0] RR_RST = RR_W'(1);
`else
  localparam logic [RR_W-1:0] RR_RST = '0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  vc_no;
  } word_t;

  word_t              out_q;
  logic [RR_W-1:0]    rr, rr_nxt, gnt_idx;
  logic [NUM_REQ-1:0] elig, nz, ovf;
  logic               free, gnt_any, rr_upd;
  logic               unused_ret;

  assign unused_ret = ^mob_credit_return;

  always_comb begin : p_arb
    int j;
    int n;
    j         = 0;
    n         = 0;
    free      = !mob_lo_valid || mob_lo_ready;
    elig      = req_valid & nz & {NUM_REQ{link_up && free}};
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    rr_upd    = 1'b0;
`ifdef ECI_MOB_LO_SCHED_PRIO0_EN
    // Requester 0 bypasses the pointer; the ring covers 1..NUM_REQ-1.
    if (elig[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        j = int'(rr) + k;
        if (j >= NUM_REQ) j = j - (NUM_REQ - 1);
        if (!gnt_any && elig[RR_W'(j)]) begin
          gnt_any = 1'b1;
          gnt_idx = RR_W'(j);
          rr_upd  = 1'b1;
        end
      end
    end
    n = int'(gnt_idx) + 1;
    if (n >= NUM_REQ) n = 1;
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && elig[RR_W'(j)]) begin
        gnt_any = 1'b1;
        gnt_idx = RR_W'(j);
        rr_upd  = 1'b1;
      end
    end
    n = int'(gnt_idx) + 1;
    if (n >= NUM_REQ) n = 0;
`endif
    rr_nxt = RR_W'(n);
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pool
    eci_mob_lo_pool #(
      .CNT_W       (CNT_W),
      .CREDIT_INIT (CREDIT_INIT)
    ) u_pool (
      .clk     (clk),
      .reset   (reset),
      .link_up (link_up),
      .grant   (req_ready[i]),
      .ret     (mob_credit_return[i]),
      .nz      (nz[i]),
      .ovf     (ovf[i])
    );
  end

  assign credits_avail = nz;
  assign mob_lo_data   = out_q.data;
  assign mob_lo_vc_no  = out_q.vc_no;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_q          <= '0;
      mob_lo_valid   <= 1'b0;
      rr             <= RR_RST;
      err_credit_ovf <= 1'b0;
    end else begin
      if (gnt_any) begin
        out_q        <= '{data: req_data[gnt_idx], vc_no: req_vc_no[gnt_idx]};
        mob_lo_valid <= 1'b1;
      end else if (mob_lo_ready) begin
        mob_lo_valid <= 1'b0;
      end
      if (!link_up)    rr <= RR_RST;
      else if (rr_upd) rr <= rr_nxt;
      if (|ovf) err_credit_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_eci_mob_lo_sched.sv
// Directed bench for eci_mob_lo_sched (default build, CREDIT_INIT=2) with an output-word scoreboard.
module tb_eci_mob_lo_sched;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0][63:0] req_data;
  logic [N-1:0][3:0]  req_vc_no;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [63:0]       mob_lo_data;
  logic [3:0]        mob_lo_vc_no;
  logic              mob_lo_valid;
  logic              mob_lo_ready;
  logic [12:0]       mob_credit_return;
  logic              link_up;
  logic [N-1:0]      credits_avail;
  logic              err_credit_ovf;

  eci_mob_lo_sched #(.NUM_REQ(N), .CREDIT_INIT(2), .CNT_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_data          (req_data),
    .req_vc_no         (req_vc_no),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .mob_lo_data       (mob_lo_data),
    .mob_lo_vc_no      (mob_lo_vc_no),
    .mob_lo_valid      (mob_lo_valid),
    .mob_lo_ready      (mob_lo_ready),
    .mob_credit_return (mob_credit_return),
    .link_up           (link_up),
    .credits_avail     (credits_avail),
    .err_credit_ovf    (err_credit_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  vc;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int seq   = 0;
  logic [63:0] held_d;

  function automatic logic [63:0] word(input int i, input int s);
    return {8'(i), 8'hA5, 48'(s)};
  endfunction

  function automatic logic [3:0] vcw(input int i, input int s);
    return 4'(i + s);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_data[i]  = word(i, seq);
      req_vc_no[i] = vcw(i, seq);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: retire any accepted word against the scoreboard, check the grant,
  // queue the word a grant should produce, then advance the stimulus.
  task automatic cyc(input logic [N-1:0] exp_rdy, input string tag);
    exp_t e;
    @(negedge clk);
    if (mob_lo_valid === 1'b1 && mob_lo_ready === 1'b1) begin
      if (sb.size() == 0) chk({tag, "_unexpected_word"}, 64'(mob_lo_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk({tag, "_data"}, mob_lo_data, e.d);
        chk({tag, "_vc"}, 64'(mob_lo_vc_no), 64'(e.vc));
      end
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < N; i++)
      if (exp_rdy[i]) sb.push_back('{d: word(i, seq), vc: vcw(i, seq)});
    @(posedge clk);
    #1;
    seq++;
    drive();
  endtask

  initial begin
    reset = 1'b1; link_up = 1'b0; req_valid = '0; mob_lo_ready = 1'b1;
    mob_credit_return = '0; drive();
    #12;
    chk("rst_valid", 64'(mob_lo_valid), 64'd0);
    chk("rst_data", mob_lo_data, 64'd0);
    chk("rst_vc", 64'(mob_lo_vc_no), 64'd0);
    chk("rst_avail", 64'(credits_avail), 64'hFF);
    chk("rst_ovf", 64'(err_credit_ovf), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // round-robin fairness: 0..7 then 0 again
    link_up = 1'b1; req_valid = '1;
    for (int k = 0; k < 9; k++) cyc(8'(1 << (k % N)), "rr");
    req_valid = '0;
    cyc('0, "rr_drain");
    chk("rr_avail", 64'(credits_avail), 64'hFE);

    // link bounce reloads every pool
    link_up = 1'b0; cyc('0, "reload");
    link_up = 1'b1;
    chk("reload_avail", 64'(credits_avail), 64'hFF);

    // credit exhaustion on requester 3, then a single return
    req_valid = 8'h08;
    cyc(8'h08, "ex1"); cyc(8'h08, "ex2"); cyc('0, "ex3");
    chk("ex_avail", 64'(credits_avail), 64'hF7);
    mob_credit_return = 13'h008; cyc('0, "ex_ret");
    mob_credit_return = '0;
    cyc(8'h08, "ex_extra"); cyc('0, "ex_done"); cyc('0, "ex_done2");

    // backpressure: word held while ready is low, handoff on release
    req_valid = 8'h02; mob_lo_ready = 1'b0;
    held_d = word(1, seq);
    cyc(8'h02, "bp_grant");
    for (int k = 0; k < 5; k++) begin
      cyc('0, "bp_hold");
      chk("bp_data", mob_lo_data, held_d);
      chk("bp_valid", 64'(mob_lo_valid), 64'd1);
    end
    mob_lo_ready = 1'b1;
    cyc(8'h02, "bp_release"); cyc('0, "bp_drain");
    req_valid = '0;

    // grant and return on pool 2 at counter 1 leave it at 1
    req_valid = 8'h04;
    cyc(8'h04, "sim1");
    mob_credit_return = 13'h004; cyc(8'h04, "sim2");
    mob_credit_return = '0;
    cyc(8'h04, "sim3"); cyc('0, "sim4");
    chk("sim_avail", 64'(credits_avail), 64'hF1);
    req_valid = '0;

    // fill pool 6 from 2 to 31, then one more return overflows
    mob_credit_return = 13'h040;
    for (int k = 0; k < 29; k++) cyc('0, "ovf_fill");
    chk("ovf_not_yet", 64'(err_credit_ovf), 64'd0);
    cyc('0, "ovf_hit");
    mob_credit_return = '0;
    chk("ovf_set", 64'(err_credit_ovf), 64'd1);
    cyc('0, "ovf_idle"); cyc('0, "ovf_idle");
    chk("ovf_sticky", 64'(err_credit_ovf), 64'd1);

    // link drop with a word pending
    req_valid = 8'h10; mob_lo_ready = 1'b0;
    cyc(8'h10, "ld_grant");
    link_up = 1'b0; req_valid = '1; mob_credit_return = '1;
    for (int k = 0; k < 3; k++) begin
      cyc('0, "ld_hold");
      chk("ld_valid_held", 64'(mob_lo_valid), 64'd1);
    end
    mob_lo_ready = 1'b1;
    cyc('0, "ld_accept");
    cyc('0, "ld_idle");
    chk("ld_valid_clear", 64'(mob_lo_valid), 64'd0);
    chk("ld_counters", 64'(credits_avail), 64'hFF);
    chk("ld_ovf_kept", 64'(err_credit_ovf), 64'd1);
    mob_credit_return = '0; link_up = 1'b1;
    cyc(8'h01, "lu_rr0"); cyc(8'h02, "lu_rr1");
    req_valid = 8'h40;
    cyc(8'h40, "lu_p6a"); cyc(8'h40, "lu_p6b"); cyc('0, "lu_p6c");
    req_valid = '0;
    cyc('0, "lu_drain");

    // asynchronous reset drops a pending word at once
    req_valid = 8'h01; mob_lo_ready = 1'b0;
    cyc(8'h01, "rst_grant");
    chk("rst_pre_valid", 64'(mob_lo_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(mob_lo_valid), 64'd0);
    chk("arst_data", mob_lo_data, 64'd0);
    chk("arst_ovf", 64'(err_credit_ovf), 64'd0);
    chk("arst_avail", 64'(credits_avail), 64'hFF);
    sb.delete();
    req_valid = '0;
    #1 reset = 1'b0;
    mob_lo_ready = 1'b1;
    cyc('0, "post_rst");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
